// File: rtl/fpio_pkg.sv
// Shared definitions for the fpio serial blocks.
// The state enum is kept here so a future receiver can use the same encoding.
package fpio_pkg;

  localparam int FPIO_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } fpio_uart_tx_state_e;

endpackage

// File: rtl/fpio_baud_gen.sv
// Bit-period timer: counts divisor-1 down to 0 and flags the last cycle of each bit.
// A divisor of 0 behaves as 1, giving a tick on every clock.
module fpio_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] reload;

  always_comb begin
    reload = (divisor == '0) ? '0 : (divisor - DIV_WIDTH'(1));
    tick   = (cnt_q == '0);
  end

  // The count restarts on every tick so consecutive bits in one state need no load.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load || tick) begin
      cnt_q <= reload;
    end else begin
      cnt_q <= cnt_q - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fpio_uart_tx.sv
// Serial transmitter fed from the fpio host-to-external FIFO.
// Sends start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module fpio_uart_tx
  import fpio_pkg::*;
#(
  parameter int FIFO_BITS  = 8,
  parameter int DATA_WIDTH = FPIO_DATA_WIDTH,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  divisor,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [FIFO_BITS:0]    in_avail,
  output logic                  in_pop,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  logic [2:0]            state_q;
  logic [2:0]            nxt_state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  stop_cnt_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  par_en_q;
  logic                  two_stop_q;
  logic                  parity_q;
  logic                  txd_q;
  logic                  nxt_txd;
  logic                  tick;
  logic                  stop_end;
  logic                  start_ok;
  logic                  baud_load;
  logic [DIV_WIDTH-1:0]  baud_div;

  // The pop and done pulses are combinational so a new byte is consumed in the
  // very cycle the previous frame's last stop bit ends; rstn gates both.
  always_comb begin
    stop_end = (state_q == ST_STOP) && tick && (!two_stop_q || stop_cnt_q);
    start_ok = rstn && enable && (in_avail != '0);
    in_pop   = start_ok && ((state_q == ST_IDLE) || stop_end);
    tx_done  = rstn && stop_end;
    busy     = (state_q != ST_IDLE);
  end

  always_comb begin
    nxt_state = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_pop) nxt_state = ST_START;
      end
      ST_START: begin
        if (tick) nxt_state = ST_DATA;
      end
      ST_DATA: begin
        if (tick && (bit_cnt_q == LAST_BIT)) nxt_state = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (tick) nxt_state = ST_STOP;
      end
      ST_STOP: begin
        if (stop_end) nxt_state = in_pop ? ST_START : ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // A new frame times its start bit from the live divisor; later bits use the latched copy.
  always_comb begin
    baud_load = in_pop || (nxt_state != state_q);
    baud_div  = in_pop ? divisor : div_q;
  end

  fpio_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk     (clk),
    .rstn    (rstn),
    .load    (baud_load),
    .divisor (baud_div),
    .tick    (tick)
  );

  // The pin is registered from the next state so it never glitches on decode.
  always_comb begin
    nxt_txd = 1'b1;
    case (nxt_state)
      ST_START:  nxt_txd = 1'b0;
      ST_DATA:   nxt_txd = ((state_q == ST_DATA) && tick) ? shift_q[1] : shift_q[0];
      ST_PARITY: nxt_txd = parity_q;
      default:   nxt_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q <= nxt_state;
      txd_q   <= nxt_txd;
      if (in_pop) begin
        shift_q    <= in_data;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        div_q      <= divisor;
        par_en_q   <= parity_en;
        two_stop_q <= two_stop;
        parity_q   <= (^in_data) ^ parity_odd;
      end else begin
        if ((state_q == ST_DATA) && tick) begin
          shift_q   <= shift_q >> 1;
          bit_cnt_q <= bit_cnt_q + BW'(1);
        end
        if ((state_q == ST_STOP) && tick && !stop_end) begin
          stop_cnt_q <= 1'b1;
        end
      end
    end
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_fpio_uart_tx.sv
// Self-checking bench for fpio_uart_tx: a queue FIFO feeds the DUT and a
// frame-level model predicts txd, busy, tx_done and in_pop every cycle.
module tb_fpio_uart_tx;

  logic        clk        = 1'b0;
  logic        rstn       = 1'b0;
  logic        enable     = 1'b0;
  logic [15:0] divisor    = 16'd4;
  logic        parity_en  = 1'b0;
  logic        parity_odd = 1'b0;
  logic        two_stop   = 1'b0;
  logic [7:0]  in_data    = 8'h00;
  logic [8:0]  in_avail   = 9'd0;
  logic        in_pop;
  logic        txd;
  logic        busy;
  logic        tx_done;

  fpio_uart_tx #(
    .FIFO_BITS  (8),
    .DATA_WIDTH (8),
    .DIV_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .divisor    (divisor),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .in_data    (in_data),
    .in_avail   (in_avail),
    .in_pop     (in_pop),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo[$];
  bit         exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int pops = 0;
  int dones = 0;
  int exp_dones = 0;
  int cyc = 0;
  int pop_cyc = 0;
  int last_len = 0;
  int last_done_cyc = 0;
  int first_pop_cyc = -1;
  bit mon_on = 1'b0;
  bit pop_seen = 1'b0;
  bit m_busy, m_txd, m_done, m_pop;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic refresh_fifo();
    in_avail = 9'(fifo.size());
    in_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    refresh_fifo();
  endtask

  task automatic applyStimulus(input int div, input bit pen, input bit podd, input bit two);
    divisor    = 16'(div);
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = two;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected line waveform of one frame, one entry per clock.
  task automatic push_frame(input logic [7:0] d, input int div, input bit pen, input bit podd,
                            input bit two);
    int bt;
    bit bits[$];
    bt = (div == 0) ? 1 : div;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ podd);
    bits.push_back(1'b1);
    if (two) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int r = 0; r < bt; r++) exp_q.push_back(bits[k]);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      m_busy = (exp_q.size() != 0);
      m_txd  = m_busy ? exp_q[0] : 1'b1;
      m_done = rstn && (exp_q.size() == 1);
      m_pop  = rstn && enable && (fifo.size() != 0) && (exp_q.size() <= 1);
      checkOutput("txd", txd, m_txd);
      checkOutput("busy", busy, m_busy);
      checkOutput("tx_done", tx_done, m_done);
      checkOutput("in_pop", in_pop, m_pop);
      if (m_busy) void'(exp_q.pop_front());
      if (m_done) exp_dones++;
      if (tx_done) begin
        dones++;
        last_len = cyc - pop_cyc;
        last_done_cyc = cyc;
      end
      if (!rstn) exp_q.delete();
      else if (m_pop) push_frame(fifo[0], int'(divisor), parity_en, parity_odd, two_stop);
      if (in_pop) begin
        pops++;
        pop_cyc = cyc;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        pop_seen = 1'b1;
      end
    end
  end

  // The upstream FIFO drops its head once the consuming edge has passed.
  always @(posedge clk) begin
    #1;
    if (pop_seen) begin
      pop_seen = 1'b0;
      if (fifo.size() != 0) void'(fifo.pop_front());
      refresh_fifo();
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step(1);
      if (exp_q.size() == 0 && !busy && (fifo.size() == 0 || !enable)) done = 1'b1;
    end
    if (!done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_pop(input int budget, input string tag);
    int p0;
    bit done;
    p0 = pops;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step(1);
      if (pops != p0) done = 1'b1;
    end
    if (!done) checkOutput({tag, "_pop_timeout"}, 32'd0, 32'd1);
  endtask

  int p0, d0, ncyc, nbytes;

  initial begin
    rstn = 1'b0;
    step(3);
    checkOutput("rst_txd", txd, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pop", in_pop, 0);
    checkOutput("rst_done", tx_done, 0);
    mon_on = 1'b1;
    rstn = 1'b1;
    step(2);

    // 0xA5 at divisor 4, no parity, one stop bit.
    applyStimulus(4, 0, 0, 0);
    p0 = pops; d0 = dones;
    push_byte(8'hA5);
    enable = 1'b1;
    wait_idle(200, "a5");
    checkOutput("a5_pops", pops - p0, 1);
    checkOutput("a5_dones", dones - d0, 1);
    checkOutput("a5_len", last_len, 40);

    // Divisor 2 with even/odd parity, then two stop bits.
    applyStimulus(2, 1, 0, 0);
    push_byte(8'hA5);
    wait_idle(200, "par_even");
    checkOutput("par_even_len", last_len, 22);
    applyStimulus(2, 1, 1, 0);
    push_byte(8'hA5);
    wait_idle(200, "par_odd");
    checkOutput("par_odd_len", last_len, 22);
    applyStimulus(2, 1, 1, 1);
    push_byte(8'hA5);
    wait_idle(200, "two_stop");
    checkOutput("two_stop_len", last_len, 24);

    // Divisor 0: two back-to-back frames at one clock per bit.
    enable = 1'b0;
    applyStimulus(0, 0, 0, 0);
    step(2);
    push_byte(8'h00);
    push_byte(8'hFF);
    first_pop_cyc = -1;
    p0 = pops;
    enable = 1'b1;
    wait_idle(200, "div0");
    checkOutput("div0_pops", pops - p0, 2);
    checkOutput("div0_total", last_done_cyc - first_pop_cyc, 20);
    checkOutput("div0_len2", last_len, 10);

    // Empty FIFO with enable held.
    p0 = pops;
    step(100);
    checkOutput("empty_pops", pops - p0, 0);
    checkOutput("empty_busy", busy, 0);

    // Reset mid-frame, then the next byte goes out normally.
    applyStimulus(4, 0, 0, 0);
    d0 = dones;
    push_byte(8'h3C);
    push_byte(8'h81);
    wait_pop(50, "rst_mid");
    step(14);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    checkOutput("rst_mid_txd", txd, 1);
    checkOutput("rst_mid_busy", busy, 0);
    wait_idle(300, "rst_mid");
    checkOutput("rst_mid_dones", dones - d0, 1);
    checkOutput("rst_mid_fifo", fifo.size(), 0);

    // Enable dropped mid-frame with three bytes queued.
    enable = 1'b0;
    step(2);
    d0 = dones; p0 = pops;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    enable = 1'b1;
    wait_pop(20, "en_drop");
    enable = 1'b0;
    wait_idle(300, "en_drop");
    step(20);
    checkOutput("en_drop_dones", dones - d0, 1);
    checkOutput("en_drop_pops", pops - p0, 1);
    checkOutput("en_drop_avail", in_avail, 2);
    fifo.delete();
    refresh_fifo();

    // Randomized traffic with mid-frame config churn, enable toggles and rare resets.
    for (int it = 0; it < 150; it++) begin
      applyStimulus($urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      nbytes = $urandom_range(1, 3);
      for (int b = 0; b < nbytes; b++) if (fifo.size() < 200) push_byte(8'($urandom));
      enable = 1'b1;
      ncyc = $urandom_range(20, 120);
      for (int c = 0; c < ncyc; c++) begin
        step(1);
        if ($urandom_range(0, 15) == 0) divisor = 16'($urandom_range(0, 5));
        if ($urandom_range(0, 15) == 0) parity_en = ~parity_en;
        if ($urandom_range(0, 15) == 0) parity_odd = ~parity_odd;
        if ($urandom_range(0, 15) == 0) two_stop = ~two_stop;
        if ($urandom_range(0, 40) == 0) enable = ~enable;
        if ($urandom_range(0, 800) == 0) begin
          rstn = 1'b0;
          step(1);
          rstn = 1'b1;
        end
      end
    end
    enable = 1'b1;
    wait_idle(40000, "drain");
    checkOutput("drain_fifo", fifo.size(), 0);
    checkOutput("done_count", dones, exp_dones);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
